// File: rtl/sponge_tag_unit.sv
// sponge_tag_unit: drives the SpongeWrap tag phase, streams tag words out (wrap) or
// checks them in constant time (unwrap). Optional build macro: SPONGE_TAG_HIDE_EN.
module sponge_tag_unit #(
   parameter  int RATE       = 16,
   parameter  int TAG_SIZE   = 64,
   localparam int TAG_BLOCKS = TAG_SIZE / RATE,
   localparam int CNT_W      = $clog2(TAG_BLOCKS + 1)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic             unwrap_i,
   input  logic [RATE-1:0]  exp_data_i,
   output logic [CNT_W-1:0] exp_index_o,
   output logic             sw_start_continue_o,
   input  logic             sw_busy_i,
   input  logic [RATE-1:0]  sw_data_out_i,
   input  logic             sw_data_out_ready_i,
   output logic [RATE-1:0]  tag_out_o,
   output logic             tag_out_valid_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             tag_ok_o,
   output logic             error_o
);

   // IDLE wait start | ISSUE fetch word | LAUNCH engine TAG cycle | WAIT permutation | DONE verdict
   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_LAUNCH, S_WAIT, S_DONE} state_t;

   state_t           state_q, state_d;
   logic             unwrap_q, mismatch_q, error_q, tag_ok_q, tag_valid_q;
   logic [CNT_W-1:0] cnt_q;
   logic [RATE-1:0]  tag_q;
   logic             accept, fire, more, hide_word;

   assign accept = (state_q == S_IDLE) && start_i;
   assign fire   = (state_q == S_ISSUE) && !sw_busy_i;
   assign more   = cnt_q < CNT_W'(TAG_BLOCKS);

`ifdef SPONGE_TAG_HIDE_EN
   assign hide_word = unwrap_q;
`else
   assign hide_word = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start_i) state_d = S_ISSUE;
         S_ISSUE:  if (!sw_busy_i) state_d = sw_data_out_ready_i ? S_LAUNCH : S_DONE;
         S_LAUNCH: state_d = S_WAIT;
         S_WAIT:   if (!sw_busy_i) state_d = more ? S_ISSUE : S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      sw_start_continue_o = fire;
      busy_o              = (state_q != S_IDLE);
      done_o              = (state_q == S_DONE);
   end

   // Every word is fetched and compared regardless of earlier mismatches.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         unwrap_q    <= 1'b0;
         mismatch_q  <= 1'b0;
         error_q     <= 1'b0;
         tag_ok_q    <= 1'b0;
         tag_valid_q <= 1'b0;
         cnt_q       <= '0;
         tag_q       <= '0;
      end else begin
         tag_valid_q <= 1'b0;
         if (accept) begin
            unwrap_q   <= unwrap_i;
            mismatch_q <= 1'b0;
            error_q    <= 1'b0;
            tag_ok_q   <= 1'b0;
            cnt_q      <= '0;
`ifdef SPONGE_TAG_HIDE_EN
            if (unwrap_i) tag_q <= '0;
`endif
         end
         if (fire) begin
            if (sw_data_out_ready_i) begin
               cnt_q      <= cnt_q + CNT_W'(1);
               mismatch_q <= mismatch_q | (unwrap_q & (sw_data_out_i != exp_data_i));
               if (!hide_word) begin
                  tag_q       <= sw_data_out_i;
                  tag_valid_q <= 1'b1;
               end
            end else begin
               error_q <= 1'b1;
            end
         end
         if ((state_q == S_WAIT) && !sw_busy_i && !more)
            tag_ok_q <= unwrap_q & ~mismatch_q & ~error_q;
      end
   end

   assign exp_index_o     = cnt_q;
   assign tag_out_o       = tag_q;
   assign tag_out_valid_o = tag_valid_q;
   assign tag_ok_o        = tag_ok_q;
   assign error_o         = error_q;

endmodule

// File: tb/tb_sponge_tag_unit.sv
// tb_sponge_tag_unit: directed and randomized runs of sponge_tag_unit against a
// behavioural SpongeWrap engine model and a word-list reference model.
module tb_sponge_tag_unit;
   localparam int RATE     = 16;
   localparam int TAG_SIZE = 64;
   localparam int NW       = TAG_SIZE / RATE;
`ifdef SPONGE_TAG_HIDE_EN
   localparam bit HIDE = 1'b1;
`else
   localparam bit HIDE = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic            unwrap = 1'b0;
   logic [RATE-1:0] exp_data;
   logic [2:0]      exp_index;
   logic            sw_start_continue;
   logic            sw_busy;
   logic [RATE-1:0] sw_data_out;
   logic            sw_data_out_ready;
   logic [RATE-1:0] tag_out;
   logic            tag_out_valid, busy, done, tag_ok, error;

   logic [RATE-1:0] eng_words [NW];
   logic [RATE-1:0] exp_words [NW];
   int              eng_p = 4;
   int              eng_cnt;
   logic [1:0]      eng_idx;
   logic            eng_ready = 1'b1;

   logic [RATE-1:0] got_q [$];
   logic [2:0]      idx_q [$];
   logic            tag_nz;
   int              checks = 0;
   int              errors = 0;

   sponge_tag_unit #(.RATE(RATE), .TAG_SIZE(TAG_SIZE)) dut (
      .clk_i(clk), .reset_i(rst), .start_i(start), .unwrap_i(unwrap),
      .exp_data_i(exp_data), .exp_index_o(exp_index),
      .sw_start_continue_o(sw_start_continue), .sw_busy_i(sw_busy),
      .sw_data_out_i(sw_data_out), .sw_data_out_ready_i(sw_data_out_ready),
      .tag_out_o(tag_out), .tag_out_valid_o(tag_out_valid), .busy_o(busy),
      .done_o(done), .tag_ok_o(tag_ok), .error_o(error)
   );

   always #5 clk = ~clk;

   // Engine model: busy for eng_p cycles after each accepted start_continue (TAG + permutation).
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         eng_cnt <= 0;
         eng_idx <= 2'd0;
      end else if (sw_start_continue) begin
         eng_cnt <= eng_p;
         eng_idx <= eng_idx + 2'd1;
      end else if (eng_cnt > 0) begin
         eng_cnt <= eng_cnt - 1;
      end
   end
   assign sw_busy           = (eng_cnt != 0);
   assign sw_data_out       = eng_words[eng_idx];
   assign sw_data_out_ready = eng_ready;
   assign exp_data          = exp_words[exp_index[1:0]];

   always @(negedge clk) begin
      if (tag_out_valid) got_q.push_back(tag_out);
      if (sw_start_continue) idx_q.push_back(exp_index);
      if (tag_out != '0) tag_nz = 1'b1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      got_q.delete();
      idx_q.delete();
      tag_nz = 1'b0;
   endtask

   task automatic reset_all();
      rst = 1'b1;
      start = 1'b0;
      eng_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Start in the current cycle; lat counts cycles from the start cycle through the done cycle.
   task automatic do_run(input bit uw, input bit dbl_start, output int lat);
      clear_mon();
      unwrap = uw;
      start = 1'b1;
      lat = 1;
      while (done !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
         start = dbl_start && (lat == 2);
      end
      start = 1'b0;
   endtask

   task automatic check_run(input string name, input bit uw, input int p, input int lat,
                            input bit ok);
      int n_exp;
      n_exp = (HIDE && uw) ? 0 : NW;
      chk({name, ":latency"}, 64'(lat), 64'(NW * (p + 2) + 2));
      chk({name, ":valid_count"}, 64'(got_q.size()), 64'(n_exp));
      for (int i = 0; i < n_exp; i++)
         chk({name, ":tag_word"}, (i < got_q.size()) ? 64'(got_q[i]) : 'x, 64'(eng_words[i]));
      chk({name, ":tag_out_seen"}, 64'(tag_nz), 64'(!(HIDE && uw)));
      chk({name, ":issue_count"}, 64'(idx_q.size()), 64'(NW));
      for (int i = 0; i < NW; i++)
         chk({name, ":exp_index"}, (i < idx_q.size()) ? 64'(idx_q[i]) : 'x, 64'(i));
      chk({name, ":tag_ok"}, 64'(tag_ok), 64'(ok));
      chk({name, ":error"}, 64'(error), 64'(0));
   endtask

   initial begin
      int lat;
      bit uw, ok;
      logic [24:0] outs;

      eng_words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      exp_words = eng_words;

      #1;
      outs = {tag_out, exp_index, busy, done, tag_out_valid, sw_start_continue, tag_ok, error};
      chk("reset_outputs", 64'(outs), 64'(0));
      reset_all();

      // Wrap
      eng_p = 4;
      do_run(1'b0, 1'b0, lat);
      check_run("wrap", 1'b0, 4, lat, 1'b0);

      // Unwrap, matching words
      reset_all();
      exp_words = eng_words;
      do_run(1'b1, 1'b0, lat);
      check_run("unwrap_match", 1'b1, 4, lat, 1'b1);

      // Unwrap, mismatch at index 2: no early exit
      reset_all();
      exp_words[2] = 16'h3334;
      do_run(1'b1, 1'b0, lat);
      check_run("unwrap_mismatch", 1'b1, 4, lat, 1'b0);

      // Protocol error on first issue, with a second start pulse while busy
      reset_all();
      exp_words = eng_words;
      eng_ready = 1'b0;
      do_run(1'b1, 1'b1, lat);
      chk("proto:latency", 64'(lat), 64'(3));
      chk("proto:error", 64'(error), 64'(1));
      chk("proto:tag_ok", 64'(tag_ok), 64'(0));
      chk("proto:issue_count", 64'(idx_q.size()), 64'(1));
      chk("proto:valid_count", 64'(got_q.size()), 64'(0));
      @(posedge clk); #1;
      chk("proto:idle_after", 64'(busy), 64'(0));
      chk("proto:error_held", 64'(error), 64'(1));
      @(posedge clk); #1;
      chk("proto:start_ignored", 64'(busy), 64'(0));

      // Async reset in WAIT after two words, then a full clean run
      reset_all();
      clear_mon();
      unwrap = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("midreset:busy_before", 64'(busy), 64'(1));
      chk("midreset:words_before", 64'(got_q.size()), 64'(2));
      rst = 1'b1;
      #1;
      outs = {tag_out, exp_index, busy, done, tag_out_valid, sw_start_continue, tag_ok, error};
      chk("midreset:outputs", 64'(outs), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      do_run(1'b0, 1'b0, lat);
      check_run("after_reset", 1'b0, 4, lat, 1'b0);

      // Randomized runs: words, mode, permutation length and mismatch position
      for (int r = 0; r < 6; r++) begin
         reset_all();
         eng_p = $urandom_range(1, 6);
         for (int i = 0; i < NW; i++) eng_words[i] = 16'($urandom_range(1, 16'hffff));
         exp_words = eng_words;
         uw = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1)
            exp_words[$urandom_range(0, NW - 1)] ^= 16'(1 << $urandom_range(0, 15));
         ok = uw;
         for (int i = 0; i < NW; i++) if (exp_words[i] != eng_words[i]) ok = 1'b0;
         do_run(uw, 1'b0, lat);
         check_run("random", uw, eng_p, lat, ok);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sponge_tag_unit.md
Name: sponge_tag_unit

Overview:
Downstream companion of the SpongeWrap engine; sequences its tag phase and consumes the tag words it produces. For wrap, it streams the TAG_SIZE-bit tag out word by word. For unwrap, it compares each tag word against host-supplied expected words and reports one constant-time pass/fail verdict. It sits between the SpongeWrap instance and the crypto control unit.

Parameters:
RATE, 16, word width in bits; equals the SpongeWrap RATE; multiple of 8.
TAG_SIZE, 64, tag length in bits; must be a non-zero multiple of RATE.
(derived) TAG_BLOCKS = TAG_SIZE/RATE; CNT_W = $clog2(TAG_BLOCKS+1).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins the tag phase (ignored unless IDLE)
unwrap  in  1  compare mode; sampled on the accepted start
exp_data  in  RATE  expected tag word for index exp_index; sampled in the ISSUE cycle that fires
exp_index  out  CNT_W  index of the word being requested/captured (0..TAG_BLOCKS-1)
sw_start_continue  out  1  start_continue to the SpongeWrap engine
sw_busy  in  1  SpongeWrap busy
sw_data_out  in  RATE  SpongeWrap data_out
sw_data_out_ready  in  1  SpongeWrap data_out_ready
tag_out  out  RATE  registered tag word
tag_out_valid  out  1  one-cycle pulse; tag_out holds word exp_index-1
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
tag_ok  out  1  unwrap verdict; valid from done until the next accepted start
error  out  1  protocol error flag; valid from done until the next accepted start

Behaviour:
- Reset (async): state=IDLE, counter=0, mismatch=0; all outputs 0.
- States: IDLE, ISSUE, LAUNCH, WAIT, DONE.
- IDLE: on start, go to ISSUE. The block latches unwrap, clears the counter, mismatch, tag_ok and error.
- ISSUE: sw_start_continue = !sw_busy (combinational). When it fires:
  - sw_data_out_ready must be 1. The block captures sw_data_out into tag_out and sets mismatch |= (sw_data_out != exp_data) when unwrap is set.
  - The counter increments, tag_out_valid pulses in the next cycle, and the state goes to LAUNCH.
  - If it fires with sw_data_out_ready=0, error is set and the state goes to DONE.
  - While sw_busy=1, ISSUE holds with no side effects.
- LAUNCH: lasts one cycle and ignores sw_busy, which covers the engine's one-cycle TAG state. Next state is WAIT.
- WAIT: holds while sw_busy=1. When sw_busy=0: goes to ISSUE if counter<TAG_BLOCKS, else DONE. The final permutation must finish before done.
- DONE: done=1 for one cycle; tag_ok = unwrap & !mismatch & !error. Next state is IDLE.
- Compare: no early exit. All TAG_BLOCKS words are always fetched and compared, so latency does not depend on data.
- Latency: with an idle engine and a permutation of P busy cycles per block, done comes TAG_BLOCKS*(P+2)+2 cycles after start.
- exp_index equals the counter; it is stable in ISSUE until the cycle fires.
- In wrap mode (unwrap=0), tag_ok=0 and exp_data is ignored.
- start while busy=1 is ignored and has no effect.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The engine must be reset together with this block.

Optional Feature:
SPONGE_TAG_HIDE_EN: when defined, in unwrap mode tag_out stays 0 and tag_out_valid is suppressed, so the computed tag never leaves the block; only tag_ok is observable. When undefined, tag words are output in both modes.

Test Plan:
- Bench setup: behavioural engine model, RATE=16, TAG_SIZE=64, P=4, tag words 0x1111/0x2222/0x3333/0x4444.
- Wrap: start, unwrap=0 -> four tag_out_valid pulses with 0x1111, 0x2222, 0x3333, 0x4444 in order; done at start+26 cycles; tag_ok=0; error=0.
- Unwrap match: unwrap=1, exp_data per exp_index = model words -> done at the same cycle count; tag_ok=1.
- Unwrap mismatch at index 2 (exp 0x3334) -> all four sw_start_continue pulses still issued; done at start+26 cycles; tag_ok=0.
- Protocol error: model holds sw_data_out_ready=0 on the first issue -> error=1, done one cycle later, tag_ok=0; start pulsed during the run is ignored.
- Async reset asserted in WAIT after two words -> outputs 0 immediately; a new start then runs a full four-word sequence from exp_index=0.
- SPONGE_TAG_HIDE_EN defined, unwrap match -> no tag_out_valid pulses, tag_out=0 throughout, tag_ok=1.
